tick_scheduler: RTL and testbench
=================================

# tick_scheduler

Multi-channel countdown timer scheduler built around one shared clock-divider prescaler. Up to CH requesters submit delays measured in prescaler ticks. A round-robin arbiter admits at most one request per cycle. Each busy channel counts down on the shared tick and emits a one-cycle `done` when it expires. It replaces per-feature divider instances (blink, buzzer, scan timing) with a single sequenced resource.

## Interface
- `PRESCALE`, 50_000: clkI cycles per tick, ≥2; prescaler counter cycles 1..PRESCALE.
- `CH`, 4: number of channels, 2..8.
- `DW`, 16: delay width in ticks.
- `clkI` in 1: system clock.
- `rstN` in 1: reset, synchronous, active-low.
- `reqValid` in CH: per-channel load request.
- `reqDelay` in CH*DW: channel i delay at bits [i*DW +: DW].
- `reqReady` out CH: combinational grant; a load occurs on the edge where `reqValid[i] && reqReady[i]`.
- `cancel` in CH: abort channel i.
- `busy` out CH: channel counting.
- `done` out CH: one-cycle expiry pulse.
- `tick` out 1: prescaler tick, high for one cycle when the prescaler counter equals PRESCALE.
- `reload` in CH: present only with `TICK_SCHED_RELOAD_EN`; see Configuration.

## Operation
- Channel states are IDLE (`busy`=0) and RUN (`busy`=1). Each channel holds a DW-bit counter `cnt` and a DW-bit stored delay `dly`.
- Eligibility: channel i is eligible when `reqValid[i]`, `!busy[i]`, and `!cancel[i]`.
- Arbiter: round-robin starting at pointer `ptr`. `reqReady` is one-hot or zero and goes to the first eligible channel at or after `ptr`. After a grant to channel g, `ptr` ← (g+1) mod CH. With no grant, `ptr` holds.
- Load with D ≠ 0: `cnt` ← D, `dly` ← D, and the channel enters RUN.
- Load with D = 0: `done[i]` pulses the next cycle. The channel stays IDLE and `busy` never rises.
- Prescaler restart: if every channel is IDLE when a load occurs, the prescaler counter ← 1, so the first tick is exactly PRESCALE cycles later. Otherwise the prescaler free-runs and wraps PRESCALE→1. It also free-runs while all channels are idle.
- Countdown: on each `tick` edge, every RUN channel decrements. At the transition `cnt` 1→0, the channel enters IDLE and `done` is registered high for the next cycle.
- Cancel: `cancel[i]` in RUN forces IDLE on the next edge with no `done`. Cancel has priority over an expiry on the same edge. Cancel on an IDLE channel blocks that channel's grant in the same cycle.
- A request on a busy channel waits; `reqReady` stays low for it.
- Counter arithmetic is unsigned DW-bit. Decrement happens only when `cnt` ≥ 1, so no wrap-around.

## Timing
- Reset (`rstN`=0 at an edge) sets: `busy`=0, `done`=0, `tick`=0, all `cnt`/`dly`=0, `ptr`=0, prescaler counter=1. This applies mid-count too; pending expiries are lost and no `done` follows.
- `reqReady` is combinational from `reqValid`, `busy`, `cancel`, and `ptr`. All other outputs are registered.
- Load accepted at the edge ending cycle 0 into an all-idle scheduler: `busy` is high from cycle 1, and `done` is high in cycle D·PRESCALE+1, with `busy` low in that same cycle.
- Load into an already-running scheduler: expiry lands D−1 to D ticks later, depending on prescaler phase.
- When several channels expire on the same tick, all their `done` bits assert in the same cycle.
- A channel may be re-granted in the cycle its `done` is high, because it is already IDLE.

## Configuration
- `TICK_SCHED_RELOAD_EN` defined:
  - The `reload` port exists.
  - On expiry with `reload[i]`=1, the channel pulses `done`, sets `cnt` ← `dly`, and stays in RUN. It repeats every `dly` ticks until `cancel` or reset.
  - With `reload[i]`=0, the channel behaves as one-shot.
- Not defined: the `reload` port and the reload logic are absent. All channels are one-shot.

## Test plan
All scenarios use PRESCALE=4, CH=4, DW=8.
- **Single load:** ch1 with D=3, all idle, accepted in cycle 0 → `busy[1]`=1 in cycles 1–12; `done[1]`=1 only in cycle 13; `tick` in cycles 4, 8, 12.
- **Round-robin:** `reqValid`=4'b1111 held continuously with D=5 → grants in order ch0, ch1, ch2, ch3, one per cycle; `reqReady` is one-hot each cycle and `ptr` returns to 0.
- **Zero delay and busy request:** D=0 on ch2 → `done[2]`=1 the next cycle and `busy[2]` never rises. A second request on a busy ch0 → `reqReady[0]`=0 until ch0's `done`.
- **Cancel:** `cancel[3]` asserted in the same cycle as its expiring tick → `busy[3]`=0 next cycle and no `done[3]` pulse.
- **Reset mid-count:** ch0 and ch1 running, `rstN`=0 for one edge → next cycle all outputs are 0, `ptr`=0; no later `done` appears.
- **Reload (macro on):** ch0 with D=2, `reload[0]`=1 → `done[0]` every 8 cycles (cycles 9, 17, 25, …) and `busy[0]` stays high. Then `cancel[0]` → no further pulses.

Source files
------------

// File: rtl/tick_scheduler_if.sv
// Request/status bundle between the tick scheduler and its requesters.
// The reload vector exists only when TICK_SCHED_RELOAD_EN is defined.
interface tick_scheduler_if #(
  parameter int unsigned CH = 4,
  parameter int unsigned DW = 16
);
  logic [CH-1:0]    reqValid;
  logic [CH*DW-1:0] reqDelay;
  logic [CH-1:0]    reqReady;
  logic [CH-1:0]    cancel;
  logic [CH-1:0]    busy;
  logic [CH-1:0]    done;
  logic             tick;

`ifdef TICK_SCHED_RELOAD_EN
  logic [CH-1:0]    reload;

  modport master (
    output reqValid, reqDelay, cancel, reload,
    input  reqReady, busy, done, tick
  );

  modport slave (
    input  reqValid, reqDelay, cancel, reload,
    output reqReady, busy, done, tick
  );
`else
  modport master (
    output reqValid, reqDelay, cancel,
    input  reqReady, busy, done, tick
  );

  modport slave (
    input  reqValid, reqDelay, cancel,
    output reqReady, busy, done, tick
  );
`endif
endinterface

// File: rtl/tick_scheduler.sv
// Multi-channel countdown scheduler sharing one prescaler, with a round-robin load arbiter.
// Optional macro TICK_SCHED_RELOAD_EN adds per-channel auto-reload on expiry.
module tick_scheduler #(
  parameter int unsigned PRESCALE = 50_000,
  parameter int unsigned CH       = 4,
  parameter int unsigned DW       = 16
) (
  input  logic            clkI,
  input  logic            rstN,
  tick_scheduler_if.slave bus
);

  localparam int unsigned PW   = $clog2(PRESCALE + 1);
  localparam int unsigned PTRW = $clog2(CH);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } chState_t;

  chState_t        stateQ [CH];
  chState_t        stateD [CH];
  logic [DW-1:0]   cntQ   [CH];
  logic [DW-1:0]   cntD   [CH];
  logic [DW-1:0]   dlyQ   [CH];
  logic [DW-1:0]   dlyD   [CH];
  logic [CH-1:0]   doneQ;
  logic [CH-1:0]   doneD;
  logic [PTRW-1:0] ptrQ;
  logic [PTRW-1:0] ptrD;
  logic [PW-1:0]   preQ;
  logic [PW-1:0]   preD;
  logic            tickQ;

  logic [CH-1:0]   busyVec;
  logic [CH-1:0]   eligible;
  logic [CH-1:0]   grant;
  logic            grantValid;
  logic [PTRW-1:0] grantIdx;

  function automatic logic [PTRW-1:0] wrapIdx(input int unsigned base, input int unsigned off);
    return PTRW'((base + off) % CH);
  endfunction

  always_comb begin
    for (int unsigned i = 0; i < CH; i++) begin
      busyVec[i] = (stateQ[i] == RUN);
    end
  end

  assign eligible = bus.reqValid & ~busyVec & ~bus.cancel;

  // Round-robin pick: first eligible channel at or after ptrQ.
  always_comb begin
    grant      = '0;
    grantValid = 1'b0;
    grantIdx   = '0;
    for (int unsigned k = 0; k < CH; k++) begin
      if (!grantValid && eligible[wrapIdx(32'(ptrQ), k)]) begin
        grantValid = 1'b1;
        grantIdx   = wrapIdx(32'(ptrQ), k);
      end
    end
    if (grantValid) begin
      grant[grantIdx] = 1'b1;
    end
  end

  always_comb begin
    ptrD = ptrQ;
    if (grantValid) begin
      ptrD = (grantIdx == PTRW'(CH - 1)) ? '0 : grantIdx + PTRW'(1);
    end
  end

  // Prescaler restarts only when a load lands on a fully idle scheduler.
  always_comb begin
    preD = preQ + PW'(1);
    if (preQ == PW'(PRESCALE)) begin
      preD = PW'(1);
    end
    if ((|grant) && (busyVec == '0)) begin
      preD = PW'(1);
    end
  end

  // Per-channel next state: load, cancel, countdown and expiry.
  always_comb begin
    doneD = '0;
    for (int unsigned i = 0; i < CH; i++) begin
      stateD[i] = stateQ[i];
      cntD[i]   = cntQ[i];
      dlyD[i]   = dlyQ[i];
      case (stateQ[i])
        IDLE: begin
          if (grant[i]) begin
            if (bus.reqDelay[i*DW +: DW] == '0) begin
              doneD[i] = 1'b1;
            end else begin
              stateD[i] = RUN;
              cntD[i]   = bus.reqDelay[i*DW +: DW];
              dlyD[i]   = bus.reqDelay[i*DW +: DW];
            end
          end
        end
        RUN: begin
          if (bus.cancel[i]) begin
            stateD[i] = IDLE;
            cntD[i]   = '0;
          end else if (tickQ && (cntQ[i] != '0)) begin
            if (cntQ[i] == DW'(1)) begin
              doneD[i]  = 1'b1;
              stateD[i] = IDLE;
              cntD[i]   = '0;
`ifdef TICK_SCHED_RELOAD_EN
              if (bus.reload[i]) begin
                stateD[i] = RUN;
                cntD[i]   = dlyQ[i];
              end
`endif
            end else begin
              cntD[i] = cntQ[i] - DW'(1);
            end
          end
        end
        default: begin
          stateD[i] = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clkI) begin
    if (!rstN) begin
      for (int unsigned i = 0; i < CH; i++) begin
        stateQ[i] <= IDLE;
        cntQ[i]   <= '0;
        dlyQ[i]   <= '0;
      end
      doneQ <= '0;
      ptrQ  <= '0;
      preQ  <= PW'(1);
      tickQ <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < CH; i++) begin
        stateQ[i] <= stateD[i];
        cntQ[i]   <= cntD[i];
        dlyQ[i]   <= dlyD[i];
      end
      doneQ <= doneD;
      ptrQ  <= ptrD;
      preQ  <= preD;
      tickQ <= (preD == PW'(PRESCALE));
    end
  end

  assign bus.reqReady = grant;
  assign bus.busy     = busyVec;
  assign bus.done     = doneQ;
  assign bus.tick     = tickQ;

  // Grant must be at most one channel and only to an eligible one.
  a_grantOneHot : assert property (@(posedge clkI) disable iff (!rstN) $onehot0(grant));
  a_grantElig   : assert property (@(posedge clkI) disable iff (!rstN) (grant & ~eligible) == '0);

endmodule

// File: tb/tb_tick_scheduler.sv
// Scoreboard bench for tick_scheduler (PRESCALE=4, CH=4, DW=8); done pulses are checked by a monitor.
module tb_tick_scheduler;

  localparam int unsigned PRESCALE = 4;
  localparam int unsigned CH       = 4;
  localparam int unsigned DW       = 8;

  typedef struct {
    int            cyc;
    logic [CH-1:0] vec;
  } doneExp_t;

  logic     clkI = 1'b0;
  logic     rstN;
  int       cyc = 0;
  int       nChecks = 0;
  int       nFail = 0;
  doneExp_t expQ[$];
  doneExp_t popE;

  always #5 clkI = ~clkI;

  tick_scheduler_if #(.CH(CH), .DW(DW)) bus ();

  tick_scheduler #(
    .PRESCALE(PRESCALE),
    .CH      (CH),
    .DW      (DW)
  ) dut (
    .clkI(clkI),
    .rstN(rstN),
    .bus (bus)
  );

  always @(posedge clkI) cyc <= cyc + 1;

  // Monitor: every done pulse must match the head of the time-ordered queue.
  always @(negedge clkI) begin
    if ((|bus.done) === 1'b1) begin
      nChecks++;
      if (expQ.size() == 0) begin
        nFail++;
        $display("FAIL done_unexpected: got done=%b at cycle %0d, required no pulse", bus.done, cyc);
      end else begin
        popE = expQ.pop_front();
        if (popE.cyc != cyc || popE.vec != bus.done) begin
          nFail++;
          $display("FAIL done_event: got done=%b at cycle %0d, required done=%b at cycle %0d",
                   bus.done, cyc, popE.vec, popE.cyc);
        end
      end
    end
  end

  task automatic pushExp(input int c, input logic [CH-1:0] v);
    int idx;
    doneExp_t e;
    e.cyc = c;
    e.vec = v;
    idx = expQ.size();
    for (int i = 0; i < expQ.size(); i++) begin
      if (expQ[i].cyc > c && idx == expQ.size()) idx = i;
    end
    expQ.insert(idx, e);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic nextCycle();
    @(posedge clkI);
    #1;
  endtask

  task automatic setReq(input int ch, input logic [DW-1:0] d);
    bus.reqValid[ch]           = 1'b1;
    bus.reqDelay[ch*DW +: DW]  = d;
  endtask

  task automatic doReset();
    rstN = 1'b0;
    nextCycle();
    rstN = 1'b1;
  endtask

  task automatic chkIdleAfterReset(input string tag);
    #1;
    chk({tag, "_busy"},  32'(bus.busy),     32'h0);
    chk({tag, "_done"},  32'(bus.done),     32'h0);
    chk({tag, "_tick"},  32'(bus.tick),     32'h0);
    chk({tag, "_ready"}, 32'(bus.reqReady), 32'h0);
    chk({tag, "_ptr"},   32'(dut.ptrQ),     32'h0);
    chk({tag, "_pre"},   32'(dut.preQ),     32'h1);
  endtask

  initial begin
    int t0;
    bus.reqValid = '0;
    bus.reqDelay = '0;
    bus.cancel   = '0;
`ifdef TICK_SCHED_RELOAD_EN
    bus.reload   = '0;
`endif
    rstN = 1'b0;
    nextCycle();
    doReset();
    chkIdleAfterReset("reset");
    nextCycle();

    // Single load: ch1, D=3, into an idle scheduler.
    t0 = cyc;
    setReq(1, 8'd3);
    #1;
    chk("s1_ready", 32'(bus.reqReady), 32'h2);
    pushExp(t0 + 13, 4'b0010);
    nextCycle();
    bus.reqValid = '0;
    for (int k = 1; k <= 13; k++) begin
      #1;
      chk("s1_busy", 32'(bus.busy), (k <= 12) ? 32'h2 : 32'h0);
      chk("s1_tick", 32'(bus.tick), (k % 4 == 0) ? 32'h1 : 32'h0);
      nextCycle();
    end

    // Round-robin: all four requesting with D=5.
    doReset();
    t0 = cyc;
    bus.reqValid = '1;
    for (int c = 0; c < int'(CH); c++) bus.reqDelay[c*DW +: DW] = 8'd5;
    pushExp(t0 + 21, 4'b1111);
    for (int k = 0; k <= 4; k++) begin
      #1;
      chk("rr_ready", 32'(bus.reqReady), (k < 4) ? (32'h1 << k) : 32'h0);
      if (k == 4) begin
        chk("rr_ptr", 32'(dut.ptrQ), 32'h0);
        chk("rr_busy", 32'(bus.busy), 32'hF);
      end
      nextCycle();
    end
    bus.reqValid = '0;
    while (cyc < t0 + 22) nextCycle();

    // Zero delay on ch2 and a waiting request on busy ch0.
    t0 = cyc;
    setReq(0, 8'd2);
    #1;
    chk("z_ready0", 32'(bus.reqReady), 32'h1);
    pushExp(t0 + 9, 4'b0001);
    nextCycle();
    setReq(2, 8'd0);
    #1;
    chk("z_ready1", 32'(bus.reqReady), 32'h4);
    chk("z_busy1", 32'(bus.busy), 32'h1);
    pushExp(t0 + 2, 4'b0100);
    nextCycle();
    bus.reqValid[2] = 1'b0;
    for (int k = 2; k <= 9; k++) begin
      if (k == 9) begin
        setReq(0, 8'd1);
        pushExp(t0 + 14, 4'b0001);
      end
      #1;
      chk("z_ready", 32'(bus.reqReady), (k == 9) ? 32'h1 : 32'h0);
      chk("z_busy", 32'(bus.busy), (k == 9) ? 32'h0 : 32'h1);
      nextCycle();
    end
    bus.reqValid = '0;
    for (int k = 10; k <= 14; k++) begin
      #1;
      chk("z_busy2", 32'(bus.busy), (k < 14) ? 32'h1 : 32'h0);
      nextCycle();
    end

    // Cancel on the expiring tick, then cancel blocking an idle grant.
    t0 = cyc;
    setReq(3, 8'd2);
    #1;
    chk("c_ready", 32'(bus.reqReady), 32'h8);
    nextCycle();
    bus.reqValid = '0;
    for (int k = 1; k <= 8; k++) begin
      if (k == 8) bus.cancel[3] = 1'b1;
      #1;
      chk("c_tick", 32'(bus.tick), (k % 4 == 0) ? 32'h1 : 32'h0);
      nextCycle();
    end
    bus.cancel[3] = 1'b0;
    #1;
    chk("c_busy", 32'(bus.busy), 32'h0);
    nextCycle();
    setReq(1, 8'd4);
    bus.cancel[1] = 1'b1;
    #1;
    chk("c_block", 32'(bus.reqReady), 32'h0);
    nextCycle();
    bus.cancel[1] = 1'b0;
    #1;
    chk("c_unblock", 32'(bus.reqReady), 32'h2);
    chk("c_noload", 32'(bus.busy), 32'h0);
    bus.reqValid = '0;
    nextCycle();

    // Reset mid-count with ch0 and ch1 running.
    setReq(0, 8'd3);
    #1;
    chk("r_ready0", 32'(bus.reqReady), 32'h1);
    nextCycle();
    bus.reqValid = '0;
    setReq(1, 8'd3);
    #1;
    chk("r_ready1", 32'(bus.reqReady), 32'h2);
    nextCycle();
    bus.reqValid = '0;
    repeat (3) nextCycle();
    #1;
    chk("r_busy", 32'(bus.busy), 32'h3);
    doReset();
    chkIdleAfterReset("midreset");
    repeat (20) nextCycle();

`ifdef TICK_SCHED_RELOAD_EN
    // Auto-reload on ch0 with D=2, then cancel.
    t0 = cyc;
    setReq(0, 8'd2);
    bus.reload[0] = 1'b1;
    #1;
    chk("rl_ready", 32'(bus.reqReady), 32'h1);
    pushExp(t0 + 9, 4'b0001);
    pushExp(t0 + 17, 4'b0001);
    pushExp(t0 + 25, 4'b0001);
    nextCycle();
    bus.reqValid = '0;
    for (int k = 1; k <= 26; k++) begin
      if (k == 26) bus.cancel[0] = 1'b1;
      #1;
      chk("rl_busy", 32'(bus.busy), 32'h1);
      nextCycle();
    end
    bus.cancel[0] = 1'b0;
    #1;
    chk("rl_cancel", 32'(bus.busy), 32'h0);
    repeat (20) nextCycle();
`endif

    chk("queue_empty", 32'(expQ.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
